ps2_digit_entry: RTL and testbench
==================================

# ps2_digit_entry

Receives raw PS/2 keyboard traffic, decodes make codes for decimal digit keys (main row and keypad), and assembles four digits into a 16-bit BCD guess for the memorization game. Sits directly upstream of the input checker and display, replacing the unconnected user-input path. Frame reception is handled by an internal serial receiver; the outer block does scan-code decoding, break and extended-prefix tracking, backspace, and the 4-digit entry handshake.

## Interface

- FILTER_LEN, 8: consecutive equal synced samples required before filtered ps2 clock/data change
- TIMEOUT_CYC, 100000: clk cycles without a ps2 clock falling edge before a partial frame is abandoned (1 ms at 100 MHz)
- clk  in  1  system clock
- rst  in  1  reset rst, synchronous, active-high
- ps2_clk  in  1  asynchronous PS/2 clock from keyboard
- ps2_data  in  1  asynchronous PS/2 data from keyboard
- enable  in  1  entry phase active; digits are accepted only while high
- clear  in  1  one-cycle request to empty the entry buffer
- digits_out  out  16  BCD guess; after four digits, first entered is in [15:12]
- digit_count  out  3  digits held, 0..4
- digits_ready  out  1  high while digit_count == 4
- frame_err  out  1  one-cycle pulse on a rejected PS/2 frame

## Operation

- Reset: digits_out=0, digit_count=0, digits_ready=0, frame_err=0, prefix flags cleared, receiver idle.
- Receiver: 2-flop synchronizer on both lines, then glitch filter (FILTER_LEN). Bits sampled on filtered ps2_clk 1→0 transition. Frame: start=0, 8 data bits LSB first, odd parity, stop=1.
- Frame rejected (byte dropped, frame_err pulse) if start≠0, parity even, stop≠0→ i.e. stop≠1, or TIMEOUT_CYC elapse mid-frame. After rejection the receiver returns to idle and waits for the next start bit.
- Byte decode: 0xF0 sets break flag; 0xE0 sets ext flag. Next non-prefix byte clears both flags; if either was set, byte is ignored (key releases and extended keys never enter digits).
- Digit codes (set 2): main row 0x45,0x16,0x1E,0x26,0x25,0x2E,0x36,0x3D,0x3E,0x46 → 0..9; keypad 0x70,0x69,0x72,0x7A,0x6B,0x73,0x74,0x6C,0x75,0x7D → 0..9.
- Accept digit when enable=1 and digit_count<4: digits_out <= {digits_out[11:0], d}, digit_count+1.
- Backspace 0x66 when enable=1, 0<digit_count<4: digits_out <= {4'h0, digits_out[15:4]}, digit_count−1. Ignored at count 0 or 4.
- All other codes ignored. With enable=0, prefix tracking still runs; digits/backspace discarded.
- digit_count==4: digits_ready high; further digits and backspaces ignored until clear or rst.
- clear: digits_out=0, digit_count=0, digits_ready=0 next cycle; wins over a coincident decoded byte. Prefix flags are not affected by clear.

## Timing

- Filtered edge appears 2 + FILTER_LEN cycles after a clean pin edge.
- Receiver byte_valid: one cycle after the stop-bit falling edge is detected.
- digits_out/digit_count/digits_ready update on the cycle after byte_valid (registered outputs, no combinational path from pins).
- frame_err: asserted exactly one cycle, in the cycle after the faulting edge or the timeout expiry.
- rst mid-frame: receiver returns to idle immediately; any partial bits are discarded and no frame_err is generated.
- Receiver states: IDLE → DATA (8 bits) → PARITY → STOP → IDLE; any state other than IDLE → IDLE on timeout.

## Structure

- Shared package: scan-code constants (digit tables, BREAK=0xF0, EXT=0xE0, BKSP=0x66), receiver state enum, NUM_DIGITS=4.
- Sub-module ps2_rx: synchronizer, filter, frame FSM, parity and timeout; outputs byte[7:0], byte_valid, frame_err. ps2_digit_entry holds decode and entry logic.

## Test plan

- enable=1, send make codes 0x16,0x1E,0x26,0x25 → digits_out=0x1234, digit_count=4, digits_ready=1.
- Send 0x16, then F0 16, then 0x70 → digit_count=2, digits_out=0x0010 (release ignored, keypad 0 accepted).
- Send 0x3D, 0x3E, 0x66, 0x46 → digits_out=0x0079, digit_count=2; a fifth key at count 4 leaves digits_out unchanged.
- Frame with bad parity, then frame with stop=0 → two frame_err pulses, digits_out unchanged; clean 0x45 afterwards accepted.
- Stop ps2_clk after 5 bits for >TIMEOUT_CYC → frame_err pulse; next full frame 0x16 decodes as digit 1.
- enable=0 while sending 0x16 → ignored; with count=4 assert clear together with byte_valid of 0x1E → count=0, digits_out=0, ready=0.

Source files
------------

// File: rtl/ps2_digit_entry_pkg.sv
// Shared scan-code constants, receiver state encoding and digit lookup
// for the PS/2 digit entry path.
package ps2_digit_entry_pkg;

    localparam int NUM_DIGITS = 4;

    localparam logic [7:0] BREAK = 8'hF0;
    localparam logic [7:0] EXT   = 8'hE0;
    localparam logic [7:0] BKSP  = 8'h66;

    // Element i holds the set-2 make code for digit i.
    localparam logic [9:0][7:0] MAIN_CODES = {
        8'h46, 8'h3E, 8'h3D, 8'h36, 8'h2E,
        8'h25, 8'h26, 8'h1E, 8'h16, 8'h45
    };
    localparam logic [9:0][7:0] KP_CODES = {
        8'h7D, 8'h75, 8'h6C, 8'h74, 8'h73,
        8'h6B, 8'h7A, 8'h72, 8'h69, 8'h70
    };

    localparam logic [1:0] RX_IDLE   = 2'd0;
    localparam logic [1:0] RX_DATA   = 2'd1;
    localparam logic [1:0] RX_PARITY = 2'd2;
    localparam logic [1:0] RX_STOP   = 2'd3;

    // Returns {hit, digit}.
    function automatic logic [4:0] digit_lookup(input logic [7:0] code);
        logic [4:0] r;
        r = '0;
        for (int i = 0; i < 10; i++) begin
            if (code == MAIN_CODES[i] || code == KP_CODES[i])
                r = {1'b1, 4'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/ps2_digit_entry_rx.sv
// PS/2 serial receiver: synchronizer, glitch filter, frame FSM with
// odd-parity check and mid-frame timeout.
module ps2_rx
    import ps2_digit_entry_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] data_byte,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [1:0]    clk_sync;
    logic [1:0]    dat_sync;
    logic [FW-1:0] clk_cnt;
    logic [FW-1:0] dat_cnt;
    logic          clk_f;
    logic          clk_f_q;
    logic          dat_f;
    logic          fall;

    logic [1:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    sr;
    logic          par_ok;
    logic [TW-1:0] tmo;

    assign fall = clk_f_q & ~clk_f;

    // A filtered line only follows its synced input after FILTER_LEN
    // consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_cnt  <= '0;
            dat_cnt  <= '0;
            clk_f    <= 1'b1;
            clk_f_q  <= 1'b1;
            dat_f    <= 1'b1;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk};
            dat_sync <= {dat_sync[0], ps2_data};
            clk_f_q  <= clk_f;
            if (clk_sync[1] == clk_f) begin
                clk_cnt <= '0;
            end else if (clk_cnt == FW'(FILTER_LEN - 1)) begin
                clk_f   <= clk_sync[1];
                clk_cnt <= '0;
            end else begin
                clk_cnt <= clk_cnt + 1'b1;
            end
            if (dat_sync[1] == dat_f) begin
                dat_cnt <= '0;
            end else if (dat_cnt == FW'(FILTER_LEN - 1)) begin
                dat_f   <= dat_sync[1];
                dat_cnt <= '0;
            end else begin
                dat_cnt <= dat_cnt + 1'b1;
            end
        end
    end

    // Parity failures are reported at the stop edge so a bad frame
    // yields one error and its stop edge is not seen as a new start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RX_IDLE;
            bit_cnt    <= '0;
            sr         <= '0;
            par_ok     <= 1'b0;
            tmo        <= '0;
            data_byte  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            if (fall || state == RX_IDLE)
                tmo <= '0;
            else
                tmo <= tmo + 1'b1;
            if (state != RX_IDLE && !fall
                && tmo == TW'(TIMEOUT_CYC - 1)) begin
                state     <= RX_IDLE;
                frame_err <= 1'b1;
            end else if (fall) begin
                case (state)
                    RX_IDLE: begin
                        if (!dat_f) begin
                            state   <= RX_DATA;
                            bit_cnt <= '0;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        sr      <= {dat_f, sr[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7)
                            state <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_ok <= ^{sr, dat_f};
                        state  <= RX_STOP;
                    end
                    default: begin
                        state <= RX_IDLE;
                        if (dat_f && par_ok) begin
                            data_byte  <= sr;
                            byte_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: rtl/ps2_digit_entry.sv
// Decodes PS/2 set-2 digit make codes into a 4-digit BCD guess with
// backspace, break/extended prefix tracking and a clear handshake.
module ps2_digit_entry
    import ps2_digit_entry_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    input  logic        enable,
    input  logic        clear,
    output logic [15:0] digits_out,
    output logic [2:0]  digit_count,
    output logic        digits_ready,
    output logic        frame_err
);

    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       brk;
    logic       ext;
    logic [4:0] hit;
    logic       full;

    ps2_rx #(
        .FILTER_LEN (FILTER_LEN),
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .data_byte (rx_byte),
        .byte_valid(rx_valid),
        .frame_err (frame_err)
    );

    assign hit          = digit_lookup(rx_byte);
    assign full         = (digit_count == 3'(NUM_DIGITS));
    assign digits_ready = full;

    always_ff @(posedge clk) begin
        if (rst) begin
            brk         <= 1'b0;
            ext         <= 1'b0;
            digits_out  <= '0;
            digit_count <= '0;
        end else begin
            if (rx_valid) begin
                if (rx_byte == BREAK) begin
                    brk <= 1'b1;
                end else if (rx_byte == EXT) begin
                    ext <= 1'b1;
                end else begin
                    brk <= 1'b0;
                    ext <= 1'b0;
                end
            end
            if (clear) begin
                digits_out  <= '0;
                digit_count <= '0;
            end else if (rx_valid && enable && !brk && !ext && !full) begin
                if (hit[4]) begin
                    digits_out  <= {digits_out[11:0], hit[3:0]};
                    digit_count <= digit_count + 3'd1;
                end else if (rx_byte == BKSP && digit_count != 3'd0) begin
                    digits_out  <= {4'h0, digits_out[15:4]};
                    digit_count <= digit_count - 3'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_digit_entry.sv
// Bench for ps2_digit_entry: directed vector table, error/timeout
// sequences, and randomized keys against a digit-queue reference.
module tb_ps2_digit_entry;

    localparam int FILT = 4;
    localparam int TMO  = 2000;
    localparam int HALF = 20;

    logic        clk = 1'b0;
    logic        rst;
    logic        ps2_clk;
    logic        ps2_data;
    logic        enable;
    logic        clear;
    logic [15:0] digits_out;
    logic [2:0]  digit_count;
    logic        digits_ready;
    logic        frame_err;

    int total  = 0;
    int passed = 0;
    int err_cyc = 0;

    ps2_digit_entry #(
        .FILTER_LEN (FILT),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .enable      (enable),
        .clear       (clear),
        .digits_out  (digits_out),
        .digit_count (digit_count),
        .digits_ready(digits_ready),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) err_cyc++;

    typedef struct {
        logic        clr;
        logic        en;
        logic [7:0]  code;
        logic [15:0] exp_d;
        logic [2:0]  exp_c;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic c, logic e, logic [7:0] k,
                               logic [15:0] d, logic [2:0] n);
        vec_t r;
        r.clr = c; r.en = e; r.code = k; r.exp_d = d; r.exp_c = n;
        return r;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            passed++;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk) ps2_data = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic send(input logic [7:0] b, input logic bad_par,
                        input logic bad_stop);
        logic p;
        p = ~(^b) ^ bad_par;
        send_bits({~bad_stop, p, b, 1'b0}, 11);
        repeat (4) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk) clear = 1'b1;
        @(negedge clk) clear = 1'b0;
    endtask

    task automatic chk_out(string tag, logic [15:0] d, logic [2:0] n);
        chk({tag, ".digits"}, 32'(digits_out), 32'(d));
        chk({tag, ".count"}, 32'(digit_count), 32'(n));
        chk({tag, ".ready"}, 32'(digits_ready), 32'(n == 3'd4));
    endtask

    function automatic int ref_digit(logic [7:0] code);
        logic [7:0] mains [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                                   8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
        logic [7:0] pads [10]  = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B,
                                   8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
        for (int i = 0; i < 10; i++)
            if (code == mains[i] || code == pads[i]) return i;
        return -1;
    endfunction

    initial begin
        int e0;
        int q[$];
        bit m_brk;
        bit m_ext;
        logic [7:0] code;
        logic [15:0] md;
        bit found;
        int d;

        rst = 1'b1; ps2_clk = 1'b1; ps2_data = 1'b1;
        enable = 1'b1; clear = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_out("reset", 16'h0, 3'd0);
        chk("reset.frame_err", 32'(frame_err), 32'd0);

        tbl.push_back(v(1, 1, 8'h16, 16'h0001, 1));
        tbl.push_back(v(0, 1, 8'h1E, 16'h0012, 2));
        tbl.push_back(v(0, 1, 8'h26, 16'h0123, 3));
        tbl.push_back(v(0, 1, 8'h25, 16'h1234, 4));
        tbl.push_back(v(1, 1, 8'h16, 16'h0001, 1));
        tbl.push_back(v(0, 1, 8'hF0, 16'h0001, 1));
        tbl.push_back(v(0, 1, 8'h16, 16'h0001, 1));
        tbl.push_back(v(0, 1, 8'h70, 16'h0010, 2));
        tbl.push_back(v(1, 1, 8'h3D, 16'h0007, 1));
        tbl.push_back(v(0, 1, 8'h3E, 16'h0078, 2));
        tbl.push_back(v(0, 1, 8'h66, 16'h0007, 1));
        tbl.push_back(v(0, 1, 8'h46, 16'h0079, 2));
        tbl.push_back(v(0, 1, 8'h45, 16'h0790, 3));
        tbl.push_back(v(0, 1, 8'h36, 16'h7906, 4));
        tbl.push_back(v(0, 1, 8'h1E, 16'h7906, 4));
        tbl.push_back(v(0, 1, 8'h66, 16'h7906, 4));
        tbl.push_back(v(1, 0, 8'h16, 16'h0000, 0));
        tbl.push_back(v(0, 1, 8'hE0, 16'h0000, 0));
        tbl.push_back(v(0, 1, 8'h69, 16'h0000, 0));
        tbl.push_back(v(0, 1, 8'h69, 16'h0001, 1));
        tbl.push_back(v(1, 1, 8'h66, 16'h0000, 0));

        for (int i = 0; i < tbl.size(); i++) begin
            if (tbl[i].clr) pulse_clear();
            enable = tbl[i].en;
            send(tbl[i].code, 1'b0, 1'b0);
            chk_out($sformatf("vec%0d", i), tbl[i].exp_d, tbl[i].exp_c);
        end
        enable = 1'b1;
        chk("vec.no_frame_err", 32'(err_cyc), 32'd0);

        send(8'h16, 1'b0, 1'b0);
        e0 = err_cyc;
        send(8'h1E, 1'b1, 1'b0);
        chk("badpar.err", 32'(err_cyc - e0), 32'd1);
        send(8'h26, 1'b0, 1'b1);
        chk("badstop.err", 32'(err_cyc - e0), 32'd2);
        chk_out("baderr", 16'h0001, 3'd1);
        send(8'h45, 1'b0, 1'b0);
        chk_out("after_err", 16'h0010, 3'd2);

        e0 = err_cyc;
        send_bits({3'b111, 8'h1E, 1'b0}, 5);
        chk("tmo.early", 32'(err_cyc - e0), 32'd0);
        repeat (TMO + 200) @(negedge clk);
        chk("tmo.err", 32'(err_cyc - e0), 32'd1);
        send(8'h16, 1'b0, 1'b0);
        chk_out("after_tmo", 16'h0101, 3'd3);

        found = 1'b0;
        fork
            send(8'h1E, 1'b0, 1'b0);
            begin
                for (int k = 0; k < 2000 && !found; k++) begin
                    @(negedge clk);
                    if (dut.rx_valid === 1'b1) begin
                        found = 1'b1;
                        clear = 1'b1;
                        @(negedge clk) clear = 1'b0;
                    end
                end
            end
        join
        chk("clrbv.seen", 32'(found), 32'd1);
        chk_out("clrbv", 16'h0000, 3'd0);
        chk("clrbv.err", 32'(err_cyc - e0), 32'd1);

        m_brk = 0; m_ext = 0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                pulse_clear();
                q.delete();
            end
            enable = ($urandom_range(0, 4) != 0);
            case ($urandom_range(0, 9))
                5: code = 8'hF0;
                6: code = 8'hE0;
                7: code = 8'h66;
                8: code = 8'($urandom_range(0, 255));
                default: begin
                    d = $urandom_range(0, 9);
                    code = 8'h00;
                    for (int c = 0; c < 256; c++)
                        if (ref_digit(8'(c)) == d && (code == 8'h00
                            || $urandom_range(0, 1) == 1))
                            code = 8'(c);
                end
            endcase
            send(code, 1'b0, 1'b0);
            if (code == 8'hF0) begin
                m_brk = 1;
            end else if (code == 8'hE0) begin
                m_ext = 1;
            end else if (m_brk || m_ext) begin
                m_brk = 0; m_ext = 0;
            end else if (enable && q.size() < 4) begin
                if (ref_digit(code) >= 0)
                    q.push_back(ref_digit(code));
                else if (code == 8'h66 && q.size() > 0)
                    void'(q.pop_back());
            end
            md = '0;
            foreach (q[j]) md = 16'((md << 4) | 16'(q[j]));
            chk_out($sformatf("rnd%0d", n), md, 3'(q.size()));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
